// File: rtl/cpu_req_queue_if.sv
// CPU request/response handshake plus the cache-side issue bus, bundled so the
// queue, CPU and cache can be wired with a single port.
// master: the request queue; slave: the CPU/cache environment around it.
interface cpu_req_queue_if #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32,
  parameter int DEPTH   = 4
);
  localparam int OW = $clog2(DEPTH + 1);

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [WIDTH_A-1:0] req_addr;
  logic [WIDTH_D-1:0] req_wdata;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_write;
  logic [WIDTH_D-1:0] resp_rdata;
  logic               resp_err;
  logic [1:0]         cpu_request;
  logic [WIDTH_A-1:0] cpu_addr;
  logic [WIDTH_D-1:0] cpu_wdata;
  logic [WIDTH_D-1:0] cpu_rdata;
  logic               cache_ready;
  logic               cache_complete;
  logic [OW-1:0]      occupancy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
           cpu_rdata, cache_ready, cache_complete,
    output req_ready, resp_valid, resp_write, resp_rdata, resp_err,
           cpu_request, cpu_addr, cpu_wdata, occupancy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
           cpu_rdata, cache_ready, cache_complete,
    input  req_ready, resp_valid, resp_write, resp_rdata, resp_err,
           cpu_request, cpu_addr, cpu_wdata, occupancy
  );
endinterface

// File: rtl/cpu_req_queue.sv
// CPU request queue: DEPTH-entry FIFO in front of the cache. Issues the head
// entry, waits for completion, returns in-order responses to the CPU.
// Optional macro CPU_REQ_TIMEOUT_EN: WAIT-state watchdog of TIMEOUT_CYCLES that
// converts a missing cache_complete into an error response.
module cpu_req_queue #(
  parameter int WIDTH_A        = 32,
  parameter int WIDTH_D        = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            reset,
  cpu_req_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic               wr;
    logic [WIDTH_A-1:0] addr;
    logic [WIDTH_D-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  state_t        state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_nxt;
  logic          push, pop;
  entry_t        in_ent, head, nxt_head;

  assign push    = bus.req_valid && bus.req_ready;
  assign pop     = (state == RESP) && bus.resp_valid && bus.resp_ready;
  assign occ_nxt = occ + OW'(push) - OW'(pop);
  assign in_ent  = {bus.req_write, bus.req_addr, bus.req_wdata};
  assign head    = mem[rd_ptr];
  // Entry issued right after a pop: if the queue held only the popped entry,
  // the successor is the one being pushed this cycle and is not in mem yet.
  assign nxt_head = (occ == OW'(1)) ? in_ent : mem[rd_ptr + PW'(1)];
  assign bus.occupancy = occ;

`ifdef CPU_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  assign wait_cnt_nxt = wait_cnt + CW'(1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  // Pointer/occupancy bookkeeping and the issue/response FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_write  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      bus.cpu_request <= 2'b00;
      bus.cpu_addr    <= '0;
      bus.cpu_wdata   <= '0;
`ifdef CPU_REQ_TIMEOUT_EN
      wait_cnt        <= '0;
`endif
    end else begin
      occ           <= occ_nxt;
      bus.req_ready <= (occ_nxt != OW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case (state)
        IDLE: if (occ != '0) begin
          state           <= ISSUE;
          bus.cpu_request <= {head.wr, !head.wr};
          bus.cpu_addr    <= head.addr;
          bus.cpu_wdata   <= head.data;
        end
        ISSUE: if (bus.cache_ready) begin
          state           <= WAIT;
          bus.cpu_request <= 2'b00;
`ifdef CPU_REQ_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
        end
        WAIT: begin
          if (bus.cache_complete) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_write <= head.wr;
            bus.resp_rdata <= head.wr ? '0 : bus.cpu_rdata;
            bus.resp_err   <= 1'b0;
          end
`ifdef CPU_REQ_TIMEOUT_EN
          else if (wait_cnt_nxt == CW'(TIMEOUT_CYCLES)) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_write <= head.wr;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b1;
          end else begin
            wait_cnt       <= wait_cnt_nxt;
          end
`endif
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          if (occ_nxt != '0) begin
            state           <= ISSUE;
            bus.cpu_request <= {nxt_head.wr, !nxt_head.wr};
            bus.cpu_addr    <= nxt_head.addr;
            bus.cpu_wdata   <= nxt_head.data;
          end else begin
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
